// File: rtl/rs_bank_if.sv
// Dispatch / CDB / scheduler-facing signal bundle for the reservation-station bank,
// plus the per-entry scheduler view type.
package rs_bank_pkg;
  typedef struct packed {
    logic        valid_operands;
    logic [2:0]  ALU_op;
    logic [2:0]  ROB_entry;
    logic [1:0]  branch_type;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } rs_out_t;
endpackage

interface rs_bank_if #(
  parameter int unsigned TAG_W = 3
);
  import rs_bank_pkg::*;

  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_alu_op;
  logic [TAG_W-1:0] disp_rob_entry;
  logic [1:0]       disp_branch_type;
  logic [31:0]      disp_rs1_val;
  logic [31:0]      disp_rs2_val;
  logic             disp_rs1_rdy;
  logic             disp_rs2_rdy;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic [3:0]       consumed_bus;
  rs_out_t          rs0_data;
  rs_out_t          rs1_data;
  rs_out_t          rs2_data;
  rs_out_t          rs3_data;
  logic [2:0]       free_count;

  modport master (
    output flush, disp_valid, disp_alu_op, disp_rob_entry, disp_branch_type,
    output disp_rs1_val, disp_rs2_val, disp_rs1_rdy, disp_rs2_rdy,
    output disp_rs1_tag, disp_rs2_tag, cdb_valid, cdb_tag, cdb_value, consumed_bus,
    input  disp_ready, rs0_data, rs1_data, rs2_data, rs3_data, free_count
  );

  modport slave (
    input  flush, disp_valid, disp_alu_op, disp_rob_entry, disp_branch_type,
    input  disp_rs1_val, disp_rs2_val, disp_rs1_rdy, disp_rs2_rdy,
    input  disp_rs1_tag, disp_rs2_tag, cdb_valid, cdb_tag, cdb_value, consumed_bus,
    output disp_ready, rs0_data, rs1_data, rs2_data, rs3_data, free_count
  );
endinterface

// File: rtl/rs_bank.sv
// Four-entry reservation-station bank: allocates dispatched micro-ops, wakes operands
// from the CDB and exposes each entry to the scheduler until it is consumed.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 3
) (
  input logic       clk,
  input logic       reset,
  rs_bank_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic [31:0]      value;
    logic [TAG_W-1:0] tag;
    logic             rdy;
  } opnd_t;

  typedef struct packed {
    logic             busy;
    logic [2:0]       alu_op;
    logic [TAG_W-1:0] rob;
    logic [1:0]       br;
    opnd_t            src1;
    opnd_t            src2;
  } entry_t;

  entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
  logic                     any_free;
  logic [IdxW-1:0]          alloc_idx;
  logic [2:0]               free_cnt;
  rs_out_t                  outs [NUM_ENTRIES];

  // A pending operand captures the broadcast result; ready operands are frozen.
  function automatic opnd_t snoop(opnd_t o, logic v, logic [TAG_W-1:0] t, logic [31:0] val);
    opnd_t r;
    r = o;
    if (!o.rdy && v && (o.tag == t)) begin
      r.value = val;
      r.rdy   = 1'b1;
    end
    return r;
  endfunction

  // Descending scan so the lowest free index wins.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    free_cnt  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        any_free  = 1'b1;
        alloc_idx = IdxW'(i);
        free_cnt  = free_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    opnd_t new1, new2;
    ent_d = ent_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].src1 = snoop(ent_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        ent_d[i].src2 = snoop(ent_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        if (bus.consumed_bus[i]) ent_d[i].busy = 1'b0;
      end
    end
    new1 = snoop({bus.disp_rs1_val, bus.disp_rs1_tag, bus.disp_rs1_rdy},
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    new2 = snoop({bus.disp_rs2_val, bus.disp_rs2_tag, bus.disp_rs2_rdy},
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    // alloc_idx was free at cycle start, so a release bit for it is a no-op.
    if (bus.disp_valid && any_free) begin
      ent_d[alloc_idx].busy   = 1'b1;
      ent_d[alloc_idx].alu_op = bus.disp_alu_op;
      ent_d[alloc_idx].rob    = bus.disp_rob_entry;
      ent_d[alloc_idx].br     = bus.disp_branch_type;
      ent_d[alloc_idx].src1   = new1;
      ent_d[alloc_idx].src2   = new2;
    end
    if (bus.flush) ent_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      outs[i] = '0;
      if (ent_q[i].busy) begin
        outs[i].valid_operands = ent_q[i].src1.rdy & ent_q[i].src2.rdy;
        outs[i].ALU_op         = ent_q[i].alu_op;
        outs[i].ROB_entry      = ent_q[i].rob;
        outs[i].branch_type    = ent_q[i].br;
        outs[i].rs1            = ent_q[i].src1.value;
        outs[i].rs2            = ent_q[i].src2.value;
      end
    end
  end

  assign bus.rs0_data   = outs[0];
  assign bus.rs1_data   = outs[1];
  assign bus.rs2_data   = outs[2];
  assign bus.rs3_data   = outs[3];
  assign bus.disp_ready = any_free;
  assign bus.free_count = free_cnt;
endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: table-driven single-entry vectors through a
// scoreboard queue, plus hand sequences for wakeup, full, multi-wake, flush and reset.
module tb_rs_bank;
  import rs_bank_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_bank_if #(.TAG_W(3)) bus ();

  rs_bank #(.NUM_ENTRIES(4), .TAG_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  alu;
    logic [2:0]  rob;
    logic [1:0]  br;
    logic [31:0] v1;
    logic        r1;
    logic [2:0]  t1;
    logic [31:0] v2;
    logic        r2;
    logic [2:0]  t2;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cval;
    logic        ev;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t    vecs [7];
  rs_out_t exp_q [$];
  int      n_vec = 0;
  int      n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rs(input string name, input rs_out_t act, input rs_out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rs_out_t rs_at(input int i);
    case (i)
      0:       return bus.rs0_data;
      1:       return bus.rs1_data;
      2:       return bus.rs2_data;
      default: return bus.rs3_data;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;             bus.disp_valid = 1'b0;
    bus.disp_alu_op = 3'd0;       bus.disp_rob_entry = 3'd0;  bus.disp_branch_type = 2'd0;
    bus.disp_rs1_val = 32'd0;     bus.disp_rs2_val = 32'd0;
    bus.disp_rs1_rdy = 1'b0;      bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs1_tag = 3'd0;      bus.disp_rs2_tag = 3'd0;
    bus.cdb_valid = 1'b0;         bus.cdb_tag = 3'd0;         bus.cdb_value = 32'd0;
    bus.consumed_bus = 4'd0;
  endtask

  task automatic disp(input logic [2:0] rob, input logic [31:0] v1, input logic r1,
                      input logic [2:0] t1, input logic [31:0] v2, input logic r2,
                      input logic [2:0] t2);
    bus.disp_valid = 1'b1;     bus.disp_alu_op = 3'd0;    bus.disp_rob_entry = rob;
    bus.disp_branch_type = 2'd0;
    bus.disp_rs1_val = v1;     bus.disp_rs1_rdy = r1;     bus.disp_rs1_tag = t1;
    bus.disp_rs2_val = v2;     bus.disp_rs2_rdy = r2;     bus.disp_rs2_tag = t2;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  initial begin
    rs_out_t e, a;
    // alu rob br | v1 r1 t1 | v2 r2 t2 | cdb v tag val | exp valid rs1 rs2
    vecs[0] = '{3'd0, 3'd5, 2'd0, 32'd10, 1'b1, 3'd0, 32'd20, 1'b1, 3'd0,
                1'b0, 3'd0, 32'd0, 1'b1, 32'd10, 32'd20};
    vecs[1] = '{3'd1, 3'd2, 2'd1, 32'd55, 1'b0, 3'd6, 32'd8, 1'b1, 3'd0,
                1'b1, 3'd6, 32'd99, 1'b1, 32'd99, 32'd8};
    vecs[2] = '{3'd2, 3'd3, 2'd0, 32'd4, 1'b1, 3'd0, 32'd0, 1'b0, 3'd3,
                1'b0, 3'd0, 32'd0, 1'b0, 32'd4, 32'd0};
    vecs[3] = '{3'd3, 3'd4, 2'd2, 32'd0, 1'b0, 3'd2, 32'd6, 1'b1, 3'd0,
                1'b1, 3'd4, 32'd77, 1'b0, 32'd0, 32'd6};
    vecs[4] = '{3'd4, 3'd1, 2'd0, 32'd1234, 1'b1, 3'd7, 32'd3, 1'b1, 3'd0,
                1'b1, 3'd7, 32'd5, 1'b1, 32'd1234, 32'd3};
    vecs[5] = '{3'd5, 3'd6, 2'd3, 32'd11, 1'b1, 3'd0, 32'd0, 1'b0, 3'd1,
                1'b0, 3'd1, 32'd9, 1'b0, 32'd11, 32'd0};
    vecs[6] = '{3'd7, 3'd7, 2'd3, 32'd0, 1'b0, 3'd4, 32'd0, 1'b0, 3'd4,
                1'b1, 3'd4, 32'hCAFE, 1'b1, 32'hCAFE, 32'hCAFE};

    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_free_count", 64'(bus.free_count), 64'd4);
    chk("reset_disp_ready", 64'(bus.disp_ready), 64'd1);
    for (int i = 0; i < 4; i++) chk_rs($sformatf("reset_rs%0d", i), rs_at(i), '0);

    // Single-entry vectors: dispatch (with optional same-cycle CDB), check, release.
    for (int k = 0; k < 7; k++) begin
      idle();
      bus.disp_valid = 1'b1;            bus.disp_alu_op = vecs[k].alu;
      bus.disp_rob_entry = vecs[k].rob; bus.disp_branch_type = vecs[k].br;
      bus.disp_rs1_val = vecs[k].v1;    bus.disp_rs1_rdy = vecs[k].r1;
      bus.disp_rs1_tag = vecs[k].t1;    bus.disp_rs2_val = vecs[k].v2;
      bus.disp_rs2_rdy = vecs[k].r2;    bus.disp_rs2_tag = vecs[k].t2;
      bus.cdb_valid = vecs[k].cv;       bus.cdb_tag = vecs[k].ct;
      bus.cdb_value = vecs[k].cval;
      e.valid_operands = vecs[k].ev;  e.ALU_op = vecs[k].alu;  e.ROB_entry = vecs[k].rob;
      e.branch_type = vecs[k].br;     e.rs1 = vecs[k].e1;      e.rs2 = vecs[k].e2;
      exp_q.push_back(e);
      step();
      idle();
      a = bus.rs0_data;
      chk_rs($sformatf("vec%0d_rs0", k), a, exp_q.pop_front());
      chk($sformatf("vec%0d_free", k), 64'(bus.free_count), 64'd3);
      bus.consumed_bus = 4'b0001;
      step();
      idle();
      chk_rs($sformatf("vec%0d_released", k), bus.rs0_data, '0);
      chk($sformatf("vec%0d_free_after", k), 64'(bus.free_count), 64'd4);
    end

    // CDB wakeup, then a later broadcast of the same tag must not disturb rs2.
    disp(3'd5, 32'd10, 1'b1, 3'd0, 32'd0, 1'b0, 3'd3);
    step();
    idle();
    chk("wake_wait_valid", 64'(bus.rs0_data.valid_operands), 64'd0);
    cdb(3'd3, 32'hDEAD_BEEF);
    step();
    idle();
    chk("wake_valid", 64'(bus.rs0_data.valid_operands), 64'd1);
    chk("wake_rs2", 64'(bus.rs0_data.rs2), 64'hDEAD_BEEF);
    cdb(3'd3, 32'd7);
    step();
    idle();
    chk("wake_rs2_frozen", 64'(bus.rs0_data.rs2), 64'hDEAD_BEEF);
    bus.consumed_bus = 4'b0001;
    step();
    idle();

    // Same-cycle release of entry 0 plus dispatch: new op must go to entry 2.
    disp(3'd1, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    disp(3'd2, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    disp(3'd3, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    bus.consumed_bus = 4'b0001;
    step();
    idle();
    chk_rs("relalloc_rs0_freed", bus.rs0_data, '0);
    chk("relalloc_rs2_rob", 64'(bus.rs2_data.ROB_entry), 64'd3);
    chk("relalloc_rs1_rob", 64'(bus.rs1_data.ROB_entry), 64'd2);
    chk("relalloc_free", 64'(bus.free_count), 64'd2);
    disp(3'd4, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    disp(3'd5, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    idle();
    chk("full_rs0_rob", 64'(bus.rs0_data.ROB_entry), 64'd4);
    chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    chk("full_free", 64'(bus.free_count), 64'd0);
    disp(3'd6, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    idle();
    chk("fifth_rs0_rob", 64'(bus.rs0_data.ROB_entry), 64'd4);
    chk("fifth_rs1_rob", 64'(bus.rs1_data.ROB_entry), 64'd2);
    chk("fifth_rs2_rob", 64'(bus.rs2_data.ROB_entry), 64'd3);
    chk("fifth_rs3_rob", 64'(bus.rs3_data.ROB_entry), 64'd5);
    disp(3'd6, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    bus.consumed_bus = 4'b0100;
    #1;
    chk("full_release_ready", 64'(bus.disp_ready), 64'd0);
    step();
    idle();
    chk_rs("full_rs2_freed", bus.rs2_data, '0);
    chk("full_free_one", 64'(bus.free_count), 64'd1);
    chk("full_ready_again", 64'(bus.disp_ready), 64'd1);
    disp(3'd6, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    idle();
    chk("refill_rs2_rob", 64'(bus.rs2_data.ROB_entry), 64'd6);
    chk("refill_rs2_valid", 64'(bus.rs2_data.valid_operands), 64'd1);
    bus.consumed_bus = 4'b1111;
    step();
    idle();
    chk("multi_release_free", 64'(bus.free_count), 64'd4);

    // One broadcast wakes two entries.
    disp(3'd2, 32'd0, 1'b0, 3'd1, 32'd5, 1'b1, 3'd0);
    step();
    disp(3'd3, 32'd6, 1'b1, 3'd0, 32'd0, 1'b0, 3'd1);
    step();
    idle();
    chk("dual_wait0", 64'(bus.rs0_data.valid_operands), 64'd0);
    chk("dual_wait1", 64'(bus.rs1_data.valid_operands), 64'd0);
    cdb(3'd1, 32'd42);
    step();
    idle();
    chk("dual_valid0", 64'(bus.rs0_data.valid_operands), 64'd1);
    chk("dual_valid1", 64'(bus.rs1_data.valid_operands), 64'd1);
    chk("dual_rs0_rs1", 64'(bus.rs0_data.rs1), 64'd42);
    chk("dual_rs1_rs2", 64'(bus.rs1_data.rs2), 64'd42);
    bus.consumed_bus = 4'b0011;
    step();
    idle();

    // Flush with three busy entries and a concurrent dispatch.
    for (int i = 0; i < 3; i++) begin
      disp(3'(i + 1), 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
      step();
    end
    disp(3'd4, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    bus.flush = 1'b1;
    step();
    idle();
    for (int i = 0; i < 4; i++) chk_rs($sformatf("flush_rs%0d", i), rs_at(i), '0);
    chk("flush_free", 64'(bus.free_count), 64'd4);
    chk("flush_ready", 64'(bus.disp_ready), 64'd1);

    // Reset mid-operation discards in-flight entries.
    disp(3'd1, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_free", 64'(bus.free_count), 64'd4);
    chk_rs("midreset_rs0", bus.rs0_data, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rs_bank.md
# rs_bank

Four-entry reservation-station bank feeding the execute-stage functional-unit scheduler. It accepts dispatched micro-ops, holds them until both source operands are available, wakes operands by snooping the common data bus (CDB), and presents each entry to the scheduler as `rs0_data`..`rs3_data`. An entry is released when the scheduler returns its one-hot `consumed_bus` bit.

## Interface
- `NUM_ENTRIES`, 4, entry count; fixed, matching the 4-bit `consumed_bus`.
- `TAG_W`, 3, ROB tag width.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high; clock `clk`.
- `flush` input 1: synchronous clear of all entries (branch mispredict).
- `disp_valid` input 1: dispatch request this cycle.
- `disp_ready` output 1: at least one entry free at the start of this cycle.
- `disp_alu_op` input 3: operation class.
- `disp_rob_entry` input 3: destination ROB tag.
- `disp_branch_type` input 2: branch type.
- `disp_rs1_val`, `disp_rs2_val` input 32 each: operand values, meaningful when the matching ready bit is 1.
- `disp_rs1_rdy`, `disp_rs2_rdy` input 1 each: operand already available.
- `disp_rs1_tag`, `disp_rs2_tag` input 3 each: producing ROB tag when not ready.
- `cdb_valid` input 1, `cdb_tag` input 3, `cdb_value` input 32: result broadcast.
- `consumed_bus` input 4: one-hot release of an entry by the scheduler.
- `rs0_data`..`rs3_data` output `rs_out_t`: `valid_operands`, `ALU_op[2:0]`, `ROB_entry[2:0]`, `branch_type[1:0]`, `rs1[31:0]`, `rs2[31:0]`.
- `free_count` output 3: number of free entries, 0..4.

## Operation
- Per-entry state: `busy`, op fields, two operand slots each holding {value[31:0], tag[2:0], rdy}.
- `rsN_data.valid_operands` = `busy & rs1.rdy & rs2.rdy`. It is combinational from registered state, so it carries no combinational path from the dispatch or CDB inputs.
- `rsN_data` op and value fields come straight from entry registers. Non-busy entries drive 0.
- Allocation: when `disp_valid & disp_ready`, write the lowest-index entry that was not busy at the start of the cycle. Set `busy=1`. `disp_valid` while `disp_ready=0` is ignored with no state change.
- Dispatch/CDB bypass: if a dispatched operand has `rdy=0`, `cdb_valid=1`, and `cdb_tag` equals its tag in the same cycle, store the operand as `rdy=1` with value `cdb_value`.
- Wakeup: for every busy entry and each operand with `rdy=0` and tag equal to `cdb_tag` while `cdb_valid=1`, latch `cdb_value` and set `rdy=1`. Ready operands never change.
- Release: each `consumed_bus[i]=1` clears `busy[i]` at the clock edge. A bit for a non-busy entry is ignored. A non-one-hot value releases every set bit; this is tolerated but illegal per protocol.
- Release and allocation in the same cycle: both apply. An entry freed this cycle is not allocatable until the next cycle, because `disp_ready` and the allocation choice use start-of-cycle `busy`.
- `free_count` = number of entries with `busy=0` in registered state.

## Timing
- Reset (and flush) values: all `busy=0`, all `rdy=0`, all fields 0. Outputs: `rsN_data` = all zeros, `disp_ready=1`, `free_count=4`.
- Priority: `reset` > `flush` > release/dispatch/wakeup. A flush in the same cycle as dispatch drops the dispatch.
- Dispatch with both operands ready: `valid_operands=1` on the cycle after the accepting edge (latency 1).
- CDB wakeup: `valid_operands` rises the cycle after the CDB cycle, provided the other operand is ready.
- Release: `valid_operands`/`busy` drop the cycle after `consumed_bus` is sampled. The scheduler registers `consumed_bus` one cycle after issue, so an entry stays visible for exactly 2 cycles after selection. Duplicate-issue avoidance is the scheduler's responsibility.
- Full: `disp_ready=0` whenever `free_count=0`, including a cycle in which a release is asserted.
- Reset mid-operation: all in-flight entries are discarded with no release handshake.

## Test plan
- Reset, then dispatch `ALU_op=3'b000`, `ROB_entry=5`, `rs1=10`, `rs2=20`, both ready. Required: next cycle `rs0_data.valid_operands=1`, `rs1=10`, `rs2=20`, `free_count=3`. Then `consumed_bus=4'b0001`; next cycle `valid_operands=0`, `free_count=4`.
- Dispatch with `rs2` not ready, tag 3. Required: `valid_operands=0`. Then `cdb_valid=1`, `cdb_tag=3`, `cdb_value=32'hDEAD_BEEF`; next cycle `valid_operands=1`, `rs2=32'hDEAD_BEEF`. A later CDB with tag 3 and value 7 leaves `rs2` unchanged.
- Same-cycle bypass: dispatch `rs1` not ready with tag 6 while `cdb_tag=6`, `cdb_value=99`. Required: entry ready next cycle with `rs1=99`.
- Fill all 4 entries. Required: `disp_ready=0` and `free_count=0`; a fifth `disp_valid` is ignored. Assert `consumed_bus=4'b0100` with a dispatch in the same cycle: dispatch is dropped, entry 2 is freed, and the next dispatch lands in entry 2.
- Two busy entries both waiting on tag 1; a single CDB with tag 1 and value 42. Required: both entries wake in the same cycle with the operand equal to 42.
- `flush` with 3 busy entries plus a concurrent dispatch. Required: next cycle all `valid_operands=0`, `free_count=4`, and no entry allocated.
